// File: rtl/rsa_decrypt_if.sv
// Register bus between the Cortex-M3 fabric interface and the RSA decryption engine.
interface rsa_decrypt_if;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;

    modport master (
        output bus_write_en,
        output bus_read_en,
        output bus_addr,
        output bus_write_data,
        input  bus_read_data
    );

    modport slave (
        input  bus_write_en,
        input  bus_read_en,
        input  bus_addr,
        input  bus_write_data,
        output bus_read_data
    );
endinterface

// File: rtl/rsa_decrypt.sv
// Bus-mapped RSA decryption engine: PT = CT^d mod N.
// The exponent is scanned left to right with square-and-multiply, and each step
// uses a bit-serial interleaved (Blakley) modular multiplier.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a valid start; config registers are writable
// SQR    | R = R*R mod N, 64 cycles, multiplier bit k counts 63..0
// MUL    | R = R*C mod N, 64 cycles, entered only when d[i] = 1
module rsa_decrypt #(
    parameter int KEY_LENGTH = 64
) (
    input  logic          pclk,
    input  logic          nreset,
    rsa_decrypt_if.slave  bus,
    output logic          done_irq
);
    localparam int ACC_W = KEY_LENGTH + 2;
    localparam int IDX_W = $clog2(KEY_LENGTH);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(KEY_LENGTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SQR  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    logic [KEY_LENGTH-1:0] mod_reg, exp_reg, ct_reg, pt_reg;
    logic [KEY_LENGTH-1:0] n_w, d_w, c_w, r_w;
    logic [ACC_W-1:0]      acc;
    logic [IDX_W-1:0]      k_cnt, i_cnt;
    logic [1:0]            state;
    logic                  busy, done, err;

    logic                  wr, start_req, clr_req, start_ok;
    logic [KEY_LENGTH-1:0] mul_b;
    logic [ACC_W-1:0]      n_ext, acc_dbl, acc_red, acc_add, acc_next;

    // Config writes are locked out for the whole busy window.
    always_comb begin
        wr        = bus.bus_write_en & ~busy;
        start_req = wr && (bus.bus_addr == 8'h18) && bus.bus_write_data[0];
        clr_req   = wr && (bus.bus_addr == 8'h18) && bus.bus_write_data[1];
        start_ok  = (mod_reg >= KEY_LENGTH'(2)) && (ct_reg < mod_reg);
    end

    // One Blakley step: double, reduce, conditionally add B, reduce again.
    // Both operands stay below N, so two subtractions always suffice.
    always_comb begin
        mul_b    = (state == S_MUL) ? c_w : r_w;
        n_ext    = {2'b00, n_w};
        acc_dbl  = acc << 1;
        acc_red  = (acc_dbl >= n_ext) ? acc_dbl - n_ext : acc_dbl;
        acc_add  = r_w[k_cnt] ? acc_red + {2'b00, mul_b} : acc_red;
        acc_next = (acc_add >= n_ext) ? acc_add - n_ext : acc_add;
    end

    // Bus-visible key material and ciphertext.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            mod_reg <= '0;
            exp_reg <= '0;
            ct_reg  <= '0;
        end else if (wr) begin
            case (bus.bus_addr)
                8'h00: mod_reg[31:0]            <= bus.bus_write_data;
                8'h04: mod_reg[KEY_LENGTH-1:32] <= bus.bus_write_data;
                8'h08: exp_reg[31:0]            <= bus.bus_write_data;
                8'h0C: exp_reg[KEY_LENGTH-1:32] <= bus.bus_write_data;
                8'h10: ct_reg[31:0]             <= bus.bus_write_data;
                8'h14: ct_reg[KEY_LENGTH-1:32]  <= bus.bus_write_data;
                default: ;
            endcase
        end
    end

    // Start validation, exponent walk and result hand-off.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            pt_reg <= '0;
            n_w    <= '0;
            d_w    <= '0;
            c_w    <= '0;
            r_w    <= '0;
            acc    <= '0;
            k_cnt  <= '0;
            i_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        if (start_ok) begin
                            done  <= 1'b0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            n_w   <= mod_reg;
                            d_w   <= exp_reg;
                            c_w   <= ct_reg;
                            r_w   <= KEY_LENGTH'(1);
                            acc   <= '0;
                            k_cnt <= TOP_IDX;
                            i_cnt <= TOP_IDX;
                            state <= S_SQR;
                        end else begin
                            err  <= 1'b1;
                            done <= 1'b0;
                        end
                    end else if (clr_req) begin
                        done <= 1'b0;
                        err  <= 1'b0;
                    end
                end
                S_SQR, S_MUL: begin
                    acc   <= acc_next;
                    k_cnt <= k_cnt - 1'b1;
                    if (k_cnt == '0) begin
                        acc   <= '0;
                        k_cnt <= TOP_IDX;
                        r_w   <= acc_next[KEY_LENGTH-1:0];
                        if (state == S_SQR && d_w[i_cnt]) begin
                            state <= S_MUL;
                        end else if (i_cnt == '0) begin
                            pt_reg <= acc_next[KEY_LENGTH-1:0];
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            i_cnt <= i_cnt - 1'b1;
                            state <= S_SQR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Zero-wait-state read mux; write-only and unmapped offsets read 0.
    always_comb begin
        bus.bus_read_data = '0;
        if (bus.bus_read_en) begin
            case (bus.bus_addr)
                8'h00: bus.bus_read_data = mod_reg[31:0];
                8'h04: bus.bus_read_data = mod_reg[KEY_LENGTH-1:32];
                8'h10: bus.bus_read_data = ct_reg[31:0];
                8'h14: bus.bus_read_data = ct_reg[KEY_LENGTH-1:32];
                8'h1C: bus.bus_read_data = {29'd0, err, done, busy};
                8'h20: bus.bus_read_data = pt_reg[31:0];
                8'h24: bus.bus_read_data = pt_reg[KEY_LENGTH-1:32];
                default: bus.bus_read_data = '0;
            endcase
        end
    end

    assign done_irq = done;
endmodule
